// File: rtl/reg_read_stage_if.sv
// Register-file read port bundle: read addresses out, combinational read data back.
interface reg_read_reg_file_if #(
  parameter int unsigned PREG_W = 6
);
  logic [PREG_W-1:0] src1_reg;
  logic [PREG_W-1:0] src2_reg;
  logic [31:0]       src1_val;
  logic [31:0]       src2_val;

  modport reg_read (output src1_reg, output src2_reg, input src1_val, input src2_val);
  modport reg_file (input src1_reg, input src2_reg, output src1_val, output src2_val);
  modport master   (output src1_reg, output src2_reg, input src1_val, input src2_val);
  modport slave    (input src1_reg, input src2_reg, output src1_val, output src2_val);
endinterface

// File: rtl/reg_read_stage.sv
// Register-read stage: reads sources, merges same-cycle writeback, registers into execute.
// Optional stall counter output is enabled by defining REG_READ_PERF_CNT_EN.
module reg_read_stage #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned UOP_W     = 8,
  localparam int unsigned PREG_W   = $clog2(NUM_PREGS),
  localparam int unsigned ROB_W    = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [PREG_W-1:0] iss_src1_preg,
  input  logic [PREG_W-1:0] iss_src2_preg,
  input  logic [PREG_W-1:0] iss_dst_preg,
  input  logic [ROB_W-1:0]  iss_rob_idx,
  input  logic [UOP_W-1:0]  iss_op,
  input  logic [31:0]       iss_imm,
  reg_read_reg_file_if.reg_read rf,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic [31:0]       wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_src1_val,
  output logic [31:0]       ex_src2_val,
  output logic [PREG_W-1:0] ex_dst_preg,
  output logic [ROB_W-1:0]  ex_rob_idx,
  output logic [UOP_W-1:0]  ex_op,
  output logic [31:0]       ex_imm
`ifdef REG_READ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic        accept;
  logic [31:0] src1_sel;
  logic [31:0] src2_sel;

  assign rf.src1_reg = iss_src1_preg;
  assign rf.src2_reg = iss_src2_preg;

  assign iss_ready = !ex_valid || ex_ready;
  assign accept    = iss_valid && iss_ready && !flush;

  // The RF write for wb_preg lands at this edge, so its read data is stale now.
  always_comb begin
    src1_sel = rf.src1_val;
    if (iss_src1_preg == '0) begin
      src1_sel = 32'h0;
    end else if (wb_valid && (wb_preg == iss_src1_preg)) begin
      src1_sel = wb_data;
    end
  end

  always_comb begin
    src2_sel = rf.src2_val;
    if (iss_src2_preg == '0) begin
      src2_sel = 32'h0;
    end else if (wb_valid && (wb_preg == iss_src2_preg)) begin
      src2_sel = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_src1_val <= '0;
      ex_src2_val <= '0;
      ex_dst_preg <= '0;
      ex_rob_idx  <= '0;
      ex_op       <= '0;
      ex_imm      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_src1_val <= src1_sel;
      ex_src2_val <= src2_sel;
      ex_dst_preg <= iss_dst_preg;
      ex_rob_idx  <= iss_rob_idx;
      ex_op       <= iss_op;
      ex_imm      <= iss_imm;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

`ifdef REG_READ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (ex_valid && !ex_ready && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Register-read pipeline stage between the issue queue (upstream) and the execute units (downstream).
- Accepts one issued uop per cycle and drives its physical source tags to the physical register file.
- Merges the returned values with a same-cycle writeback bypass and registers the result into a valid/ready pipeline register for execute.
- Connects to the register file through the reg_read modport of reg_read_reg_file_if, exposed below as rf_* signals.

Parameters:
- NUM_PREGS, 64, number of physical registers; PREG_W = $clog2(NUM_PREGS).
- ROB_DEPTH, 32, ROB entries; ROB_W = $clog2(ROB_DEPTH).
- UOP_W, 8, width of the opaque opcode/control field.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline squash (mispredict/exception).
- iss_valid  in  1  issue presents a uop.
- iss_ready  out  1  stage can accept a uop this cycle.
- iss_src1_preg  in  PREG_W  source 1 physical tag.
- iss_src2_preg  in  PREG_W  source 2 physical tag.
- iss_dst_preg  in  PREG_W  destination physical tag.
- iss_rob_idx  in  ROB_W  ROB index.
- iss_op  in  UOP_W  opcode/control.
- iss_imm  in  32  immediate.
- rf_src1_reg  out  PREG_W  register-file read address 1.
- rf_src2_reg  out  PREG_W  register-file read address 2.
- rf_src1_val  in  32  register-file read data 1 (combinational).
- rf_src2_val  in  32  register-file read data 2 (combinational).
- wb_valid  in  1  writeback this cycle.
- wb_preg  in  PREG_W  writeback tag.
- wb_data  in  32  writeback value.
- ex_valid  out  1  uop valid to execute.
- ex_ready  in  1  execute accepts.
- ex_src1_val  out  32  operand 1.
- ex_src2_val  out  32  operand 2.
- ex_dst_preg  out  PREG_W  destination tag.
- ex_rob_idx  out  ROB_W  ROB index.
- ex_op  out  UOP_W  opcode.
- ex_imm  out  32  immediate.

Behaviour:
- Clocking: single clock clk; rst is synchronous and active-high.
- Reset: ex_valid=0; all ex_* payload registers=0. iss_ready=1 in the cycle after reset.
- rf_src1_reg/rf_src2_reg = iss_src1_preg/iss_src2_preg, purely combinational. Driven regardless of iss_valid.
- Operand select, per source, in priority order:
  - (a) preg==0 -> 32'h0 (hardwired zero, never bypassed).
  - (b) wb_valid && wb_preg==preg -> wb_data. The register file write lands at the clock edge, so its read data is stale in that cycle.
  - (c) otherwise rf_srcN_val.
- iss_ready = !ex_valid || ex_ready (plain pipeline register, no skid buffer).
- accept = iss_valid && iss_ready && !flush. On accept, the output register loads operands and payload at the next edge and ex_valid=1. Latency issue->execute is 1 cycle.
- ex_valid && ex_ready && !accept -> ex_valid clears next edge.
- ex_valid && !ex_ready -> all ex_* outputs hold stable; iss_ready=0. Later writebacks do not alter the held operands; they were captured complete.
- Simultaneous drain and accept (ex_valid && ex_ready && accept) -> new uop loaded, ex_valid stays 1. Full throughput of 1 uop/cycle.
- flush has priority over everything except rst: ex_valid=0 next edge, any incoming uop is dropped, payload registers are don't-care. iss_ready is unaffected by flush.
- rst asserted mid-stall or mid-flush -> reset values next edge, no partial state.
- No width arithmetic; tags are compared at full PREG_W.

Optional Feature:
- Macro REG_READ_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cycles (32 bits).
  - Increments by 1 each cycle with ex_valid && !ex_ready && !flush.
  - Saturates at 32'hFFFF_FFFF; clears to 0 on rst.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset, then iss_valid=1, src1=5, src2=6, RF returns 0x11/0x22, ex_ready=1 -> next cycle ex_valid=1, ex_src1_val=0x11, ex_src2_val=0x22, payload matches.
- src1=7 with RF returning 0xDEAD while wb_valid=1, wb_preg=7, wb_data=0xBEEF -> ex_src1_val=0xBEEF. The same with src=0 and wb_preg=0 -> ex_src1_val=0.
- Back-to-back uops A,B,C with ex_ready=1 -> ex sees A,B,C on consecutive cycles; iss_ready stays 1.
- Uop A held with ex_ready=0 for 3 cycles, wb writing A's src meanwhile -> iss_ready=0; ex outputs unchanged for all 3 cycles. With REG_READ_PERF_CNT_EN, stall_cycles=3.
- flush together with iss_valid while ex_valid=1 -> next cycle ex_valid=0; the dropped uop never appears.
- rst asserted while stalled with ex_valid=1 -> next cycle ex_valid=0, payload=0, iss_ready=1.
